// File: rtl/periph_interco_pkg.sv
// Shared types and width helpers for the peripheral interconnect arbiter.
package periph_interco_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  // The minimum is 1 bit so that a single-master build still has a legal index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_out);
    return (max_out > 0) ? $clog2(max_out + 1) : 1;
  endfunction

endpackage

// File: rtl/periph_rr_select.sv
// Round-robin picker: the search starts at ptr and wraps. The first set request wins.
module periph_rr_select
  import periph_interco_pkg::*;
#(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned IDX_W    = idx_width(N_MASTER)
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [N_MASTER-1:0] sel_onehot,
  output logic [IDX_W-1:0]    sel_idx,
  output logic                sel_valid
);

  int unsigned pos;

  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    sel_valid  = 1'b0;
    pos        = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      pos = (32'(ptr) + i) % N_MASTER;
      if (!sel_valid && req[pos]) begin
        sel_valid       = 1'b1;
        sel_idx         = IDX_W'(pos);
        sel_onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_req_arbiter.sv
// N-to-1 round-robin request arbiter toward a single peripheral port.
// Defining PERIPH_ARB_OUTSTANDING_LIMIT_EN adds a limiter on responses that are still outstanding.
module periph_req_arbiter
  import periph_interco_pkg::*;
#(
  parameter int unsigned N_MASTER        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTER-1:0]                  data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
  input  logic [N_MASTER-1:0]                  data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
  output logic [N_MASTER-1:0]                  data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [N_MASTER-1:0]                  data_ID_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_r_valid_i,
  output logic                                 busy_o
);

  localparam int unsigned IDX_W = idx_width(N_MASTER);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      rr_ptr_q, lat_idx_q;
  logic [IDX_W-1:0]      rr_idx, sel_idx;
  logic [N_MASTER-1:0]   rr_onehot, sel_onehot;
  logic                  rr_valid, sel_active, blocked, req_out, handshake;

  periph_rr_select #(
    .N_MASTER (N_MASTER),
    .IDX_W    (IDX_W)
  ) u_rr_select (
    .req        (data_req_i),
    .ptr        (rr_ptr_q),
    .sel_onehot (rr_onehot),
    .sel_idx    (rr_idx),
    .sel_valid  (rr_valid)
  );

  // While in WAIT, the latched master keeps ownership. If it drops its request, nothing goes out.
  always_comb begin
    sel_onehot = '0;
    if (state_q == WAIT) begin
      sel_idx               = lat_idx_q;
      sel_active            = data_req_i[lat_idx_q];
      sel_onehot[lat_idx_q] = 1'b1;
    end else begin
      sel_idx    = rr_idx;
      sel_active = rr_valid;
      sel_onehot = rr_onehot;
    end
  end

  // Reset also gates these paths, so the outputs stay quiet while rst_n is low.
  assign req_out      = rst_n & sel_active & ~blocked;
  assign handshake    = req_out & data_gnt_i;
  assign data_req_o   = req_out;
  assign data_gnt_o   = handshake ? sel_onehot : '0;
  assign data_ID_o    = req_out ? sel_onehot : '0;
  assign data_add_o   = data_add_i[sel_idx];
  assign data_wen_o   = data_wen_i[sel_idx];
  assign data_wdata_o = data_wdata_i[sel_idx];
  assign data_be_o    = data_be_i[sel_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lat_idx_q <= '0;
    end else begin
      if (handshake) begin
        rr_ptr_q <= (sel_idx == IDX_W'(N_MASTER - 1)) ? '0 : sel_idx + IDX_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (req_out && !data_gnt_i) begin
            state_q   <= WAIT;
            lat_idx_q <= sel_idx;
          end
        end
        WAIT: begin
          if (!blocked && (!data_req_i[lat_idx_q] || data_gnt_i)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PERIPH_ARB_OUTSTANDING_LIMIT_EN
  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [CNT_W-1:0] out_cnt_q;

  assign blocked = (out_cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign busy_o  = (state_q == WAIT) || (out_cnt_q != '0);

  // When a handshake and a response land in the same cycle, they cancel. A response at zero is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
    end else if (handshake && !data_r_valid_i) begin
      out_cnt_q <= out_cnt_q + CNT_W'(1);
    end else if (!handshake && data_r_valid_i && (out_cnt_q != '0)) begin
      out_cnt_q <= out_cnt_q - CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = {data_r_valid_i, 31'(MAX_OUTSTANDING)};
  assign blocked    = 1'b0;
  assign busy_o     = (state_q == WAIT);
`endif

endmodule

// File: tb/tb_periph_req_arbiter.sv
// Self-checking bench for periph_req_arbiter: table vectors, hand sequences and random traffic.
module tb_periph_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MAXO = 2;
`ifdef PERIPH_ARB_OUTSTANDING_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic [3:0] e_gnt;
    logic       e_req;
    logic [3:0] e_id;
    logic       e_busy;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_i;
  logic [N-1:0][AW-1:0]  add_i;
  logic [N-1:0]          wen_i;
  logic [N-1:0][DW-1:0]  wdata_i;
  logic [N-1:0][BW-1:0]  be_i;
  logic [N-1:0]          gnt_o;
  logic                  req_o;
  logic [AW-1:0]         add_o;
  logic                  wen_o;
  logic [DW-1:0]         wdata_o;
  logic [BW-1:0]         be_o;
  logic [N-1:0]          id_o;
  logic                  gnt_i;
  logic                  rv_i;
  logic                  busy_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit m_wait;
  int m_lat, m_ptr, m_cnt;
  bit e_req, e_busy, e_blk;
  logic [3:0] e_gnt, e_id;
  int e_cand;

  periph_req_arbiter #(
    .N_MASTER        (N),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BE_WIDTH        (BW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (req_i),
    .data_add_i     (add_i),
    .data_wen_i     (wen_i),
    .data_wdata_i   (wdata_i),
    .data_be_i      (be_i),
    .data_gnt_o     (gnt_o),
    .data_req_o     (req_o),
    .data_add_o     (add_o),
    .data_wen_o     (wen_o),
    .data_wdata_o   (wdata_o),
    .data_be_o      (be_o),
    .data_ID_o      (id_o),
    .data_gnt_i     (gnt_i),
    .data_r_valid_i (rv_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic [3:0] rq, logic g, logic r, logic [3:0] eg,
                             logic er, logic [3:0] ei, logic eb);
    vec_t t;
    t.req = rq; t.gnt = g; t.rv = r; t.e_gnt = eg; t.e_req = er; t.e_id = ei; t.e_busy = eb;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic rand_payload();
    for (int k = 0; k < N; k++) begin
      add_i[k]   = $urandom;
      wdata_i[k] = $urandom;
      wen_i[k]   = 1'($urandom_range(0, 1));
      be_i[k]    = 4'($urandom);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_lat = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // The expected outputs come straight from the rules. In WAIT the latched master owns the port. Otherwise there is a circular search from the pointer.
  task automatic model_eval();
    bit act;
    e_blk  = LIM && (m_cnt == MAXO);
    act    = 0;
    e_cand = 0;
    if (m_wait) begin
      e_cand = m_lat;
      act    = req_i[m_lat];
    end else begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (!act && req_i[k]) begin
          act    = 1;
          e_cand = k;
        end
      end
    end
    e_req = act && !e_blk;
    e_id  = '0;
    if (e_req) e_id[e_cand] = 1'b1;
    e_gnt  = (e_req && gnt_i) ? e_id : 4'b0000;
    e_busy = m_wait || (LIM && m_cnt > 0);
  endtask

  task automatic model_step();
    bit hs;
    hs = e_req && gnt_i;
    if (hs) m_ptr = (e_cand + 1) % N;
    if (!e_blk) begin
      if (m_wait) begin
        if (!req_i[m_lat] || gnt_i) m_wait = 0;
      end else if (e_req && !gnt_i) begin
        m_wait = 1;
        m_lat  = e_cand;
      end
    end
    if (LIM) begin
      if (hs && !rv_i) m_cnt++;
      else if (!hs && rv_i && m_cnt > 0) m_cnt--;
    end
  endtask

  task automatic apply(input logic [3:0] rq, input logic g, input logic r,
                       input bit use_tbl, input vec_t t, input string nm);
    req_i = rq; gnt_i = g; rv_i = r;
    rand_payload();
    #2;
    model_eval();
    chk({nm, ".gnt_o"},  64'(gnt_o),  64'(e_gnt));
    chk({nm, ".req_o"},  64'(req_o),  64'(e_req));
    chk({nm, ".id_o"},   64'(id_o),   64'(e_id));
    chk({nm, ".busy_o"}, 64'(busy_o), 64'(e_busy));
    if (e_req) begin
      chk({nm, ".add_o"},   64'(add_o),   64'(add_i[e_cand]));
      chk({nm, ".wen_o"},   64'(wen_o),   64'(wen_i[e_cand]));
      chk({nm, ".wdata_o"}, 64'(wdata_o), 64'(wdata_i[e_cand]));
      chk({nm, ".be_o"},    64'(be_o),    64'(be_i[e_cand]));
    end
    if (use_tbl) begin
      chk({nm, ".tbl_gnt"},  64'(gnt_o),  64'(t.e_gnt));
      chk({nm, ".tbl_req"},  64'(req_o),  64'(t.e_req));
      chk({nm, ".tbl_id"},   64'(id_o),   64'(t.e_id));
      chk({nm, ".tbl_busy"}, 64'(busy_o), 64'(t.e_busy));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    req_i = 4'($urandom); gnt_i = 1'($urandom); rv_i = 1'($urandom);
    rand_payload();
    #2;
    chk({nm, ".rst_gnt"},  64'(gnt_o),  64'd0);
    chk({nm, ".rst_req"},  64'(req_o),  64'd0);
    chk({nm, ".rst_id"},   64'(id_o),   64'd0);
    chk({nm, ".rst_busy"}, 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_seq(input vec_t q[$], input string nm);
    foreach (q[i]) apply(q[i].req, q[i].gnt, q[i].rv, 1'b1, q[i], $sformatf("%s[%0d]", nm, i));
  endtask

  vec_t dummy;
  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    rst_n = 1'b0; req_i = '0; gnt_i = 1'b0; rv_i = 1'b0;
    rand_payload();
    dummy = v(4'h0, 0, 0, 4'h0, 0, 4'h0, 0);
    model_reset();
    do_reset("init");

    // Full rotation with r_valid asserted every cycle, which keeps any counter at zero. After that, master 2 is held in WAIT and master 0 is locked out.
    tbl = '{};
    tbl.push_back(v(4'b1111, 1, 1, 4'b0001, 1, 4'b0001, 0));
    tbl.push_back(v(4'b1111, 1, 1, 4'b0010, 1, 4'b0010, 0));
    tbl.push_back(v(4'b1111, 1, 1, 4'b0100, 1, 4'b0100, 0));
    tbl.push_back(v(4'b1111, 1, 1, 4'b1000, 1, 4'b1000, 0));
    tbl.push_back(v(4'b1111, 1, 1, 4'b0001, 1, 4'b0001, 0));
    tbl.push_back(v(4'b0100, 0, 1, 4'b0000, 1, 4'b0100, 0));
    tbl.push_back(v(4'b0100, 0, 1, 4'b0000, 1, 4'b0100, 1));
    tbl.push_back(v(4'b0100, 0, 1, 4'b0000, 1, 4'b0100, 1));
    tbl.push_back(v(4'b0101, 1, 1, 4'b0100, 1, 4'b0100, 1));
    tbl.push_back(v(4'b0101, 1, 1, 4'b0001, 1, 4'b0001, 0));
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].req, tbl[i].gnt, tbl[i].rv, 1'b1, tbl[i], $sformatf("tbl[%0d]", i));

    // The latched master drops its request while in WAIT. There is no grant, and the FSM goes back to IDLE.
    seq = '{};
    seq.push_back(v(4'b0100, 0, 0, 4'b0000, 1, 4'b0100, 0));
    seq.push_back(v(4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 1));
    seq.push_back(v(4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0));
    run_seq(seq, "drop");

`ifdef PERIPH_ARB_OUTSTANDING_LIMIT_EN
    do_reset("lim");
    seq = '{};
    seq.push_back(v(4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 0)); // cnt 0 -> 1
    seq.push_back(v(4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 1)); // cnt 1 -> 2
    seq.push_back(v(4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 1)); // blocked
    seq.push_back(v(4'b0001, 1, 1, 4'b0000, 0, 4'b0000, 1)); // same-cycle rv: still blocked
    seq.push_back(v(4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 1)); // resumed, cnt -> 2
    seq.push_back(v(4'b0001, 1, 1, 4'b0000, 0, 4'b0000, 1)); // cnt -> 1
    seq.push_back(v(4'b0001, 1, 1, 4'b0001, 1, 4'b0001, 1)); // hs+rv: cnt stays 1
    seq.push_back(v(4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 1)); // cnt -> 2
    seq.push_back(v(4'b0001, 1, 0, 4'b0000, 0, 4'b0000, 1)); // blocked at 2
    seq.push_back(v(4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 1)); // cnt -> 1
    seq.push_back(v(4'b0010, 0, 0, 4'b0000, 1, 4'b0010, 1)); // enter WAIT on master 1
    seq.push_back(v(4'b0010, 0, 0, 4'b0000, 1, 4'b0010, 1));
    run_seq(seq, "limit");
    do_reset("midwait");
    seq = '{};
    seq.push_back(v(4'b1010, 1, 0, 4'b0010, 1, 4'b0010, 0)); // cnt -> 1
    seq.push_back(v(4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 1)); // cnt -> 0
    seq.push_back(v(4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 0)); // rv at 0 holds 0
    seq.push_back(v(4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0));
    run_seq(seq, "post_rst");
`else
    do_reset("midwait_pre");
    seq = '{};
    seq.push_back(v(4'b1000, 0, 0, 4'b0000, 1, 4'b1000, 0));
    seq.push_back(v(4'b1000, 0, 0, 4'b0000, 1, 4'b1000, 1));
    run_seq(seq, "wait");
    do_reset("midwait");
    seq = '{};
    seq.push_back(v(4'b1010, 1, 1, 4'b0010, 1, 4'b0010, 0));
    run_seq(seq, "post_rst");
`endif

    // Random traffic is checked against the model, with an occasional reset in between.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset($sformatf("rnd_rst%0d", i));
      end else begin
        apply(4'($urandom), 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 35),
              1'b0, dummy, $sformatf("rnd%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
